dmi_jtag_dtm: RTL
=================

Name: dmi_jtag_dtm

Overview:
- Debug Transport Module core fed directly by the FPGA scan-chain TAP. Consumes its capture/shift/update/tdi and DTMCS/DMI select strobes, and returns TDO for each chain.
- Holds the 32-bit DTMCS and 41-bit DMI shift registers.
- Converts DMI updates into valid/ready request/response transactions toward the DMI clock-domain crossing.
- Runs entirely in the TCK domain.

Parameters:
- AbitsWidth, 7, DMI address width; reported in dtmcs.abits.
- IdleCycles, 3'd1, value reported in dtmcs.idle.
- Version, 4'd1, value reported in dtmcs.version (0.13).

Ports:
- clk_i  in  1  TCK from TAP.
- rst_i  in  1  synchronous, active-high reset.
- capture_i  in  1  capture-DR strobe.
- shift_i  in  1  shift-DR strobe.
- update_i  in  1  update-DR strobe.
- tdi_i  in  1  scan data in.
- dtmcs_select_i  in  1  DTMCS chain selected.
- dtmcs_tdo_o  out  1  DTMCS scan out.
- dmi_select_i  in  1  DMI chain selected.
- dmi_tdo_o  out  1  DMI scan out.
- dmi_req_valid_o  out  1  request valid.
- dmi_req_ready_i  in  1  request accepted.
- dmi_req_addr_o  out  AbitsWidth  request address.
- dmi_req_op_o  out  2  request op: 1=read, 2=write.
- dmi_req_data_o  out  32  write data.
- dmi_resp_valid_i  in  1  response valid.
- dmi_resp_ready_o  out  1  response accepted.
- dmi_resp_data_i  in  32  read data.
- dmi_resp_resp_i  in  2  response code: 0=ok, 2=failed, 3=busy.
- dmi_clear_o  out  1  one-cycle pulse on dmihardreset.

Behaviour:
- Reset (rst_i=1 at clk edge):
  - FSM=Idle; error_q, addr_q, data_q and both shift registers are 0.
  - All outputs 0, except TDO, which is shift LSB and therefore 0.
- DTMCS read value: {14'b0, dmihardreset 0, dmireset 0, 1'b0, IdleCycles[2:0], dmistat=error_q[1:0], abits[5:0]=AbitsWidth, Version[3:0]}.
- DTMCS chain (acts only when dtmcs_select_i=1):
  - capture_i loads the read value.
  - shift_i: sr <= {tdi_i, sr[31:1]}.
  - update_i with sr[16]=1: error_q<=0 (dmireset).
  - update_i with sr[17]=1: error_q<=0, FSM<=Idle, dmi_clear_o=1 for exactly the next cycle (dmihardreset).
- DMI chain (acts only when dmi_select_i=1), layout {addr[40:34], data[33:2], op[1:0]} for AbitsWidth=7:
  - capture_i loads {addr_q, data_q, error_q}.
  - Capture while FSM!=Idle sets error_q<=3 (busy, sticky) and loads op=3.
  - shift_i: sr <= {tdi_i, sr[W-1:1]}.
- DMI update_i:
  - If error_q!=0: ignored.
  - Else if FSM!=Idle: error_q<=3.
  - Else if op is 1 or 2: latch addr/data/op into the request registers; FSM<=Request.
  - Else (op 0 or 3): no effect.
- TDO: dtmcs_tdo_o=dtmcs_sr[0]; dmi_tdo_o=dmi_sr[0]. Registered, no combinational path from tdi_i.
- FSM:
  - Idle: no request outstanding.
  - Request: dmi_req_valid_o=1. addr/op/data stay stable until dmi_req_valid_o & dmi_req_ready_i, then -> WaitResp.
  - WaitResp: dmi_resp_ready_o=1. On dmi_resp_valid_i: data_q<=dmi_resp_data_i; if resp!=0, error_q<=resp (2 or 3); -> Idle.
- Latency: update in cycle N -> dmi_req_valid_o=1 in cycle N+1. Response in cycle M -> Idle, and data_q visible at capture, from cycle M+1.
- Boundaries:
  - Both selects high: DTMCS actions take priority and DMI actions are suppressed.
  - dmihardreset in Request: valid drops without handshake. Allowed because dmi_clear_o flushes the downstream side in the same cycle.
  - dmihardreset in WaitResp: a late response is dropped.
  - dmireset does not abort an outstanding transaction.
  - rst_i mid-transaction: immediate return to reset state, no handshake completion.
  - Simultaneous capture, shift and update never occur, because the TAP guarantees one-hot. No priority logic is required.

Decomposition:
- dm_pkg holds:
  - dtm_op_e: Nop=0, Read=1, Write=2.
  - dmi_resp codes: Success=0, Failed=2, Busy=3.
  - dtmcs_t packed struct.
  - dmi_req_t / dmi_resp_t structs.
  - DtmFsm enum: Idle, Request, WaitResp.
- Single module; no sub-module. The shift registers and FSM are small and tightly coupled.

Test Plan:
- Reset, then DTMCS capture + 32 shifts -> TDO stream LSB-first equals 0x00001071 (defaults).
- DMI update addr=0x10, data=0xDEADBEEF, op=2 -> cycle N+1 valid=1, addr=0x10, data=0xDEADBEEF, op=2; stable through a 3-cycle ready stall; resp 0 -> next capture op=0.
- Read addr=0x11 with response data 0x12345678 resp 0 -> next DMI capture/shift returns data=0x12345678, op=0, addr=0x11.
- Second DMI capture during WaitResp -> op=3 shifted out, dtmcs.dmistat=3; further updates issue no request; DTMCS write bit16 -> dmistat=0, new op=1 accepted.
- Response resp=2 -> sticky op=2 on each capture until dmireset; no new requests meanwhile.
- dmihardreset (bit17) while Request and ready=0 -> valid=0 next cycle, dmi_clear_o high exactly 1 cycle, FSM Idle, error_q=0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types for the JTAG debug transport module and the DMI link it drives.
package dm_pkg;

  typedef enum logic [1:0] {
    Nop   = 2'd0,
    Read  = 2'd1,
    Write = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DmiSuccess = 2'd0,
    DmiFailed  = 2'd2,
    DmiBusy    = 2'd3
  } dmi_resp_e;

  typedef enum logic [1:0] {
    Idle,
    Request,
    WaitResp
  } dtm_fsm_e;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  localparam int unsigned DmiResetBit     = 16;
  localparam int unsigned DmiHardResetBit = 17;
  localparam int unsigned DmiAddrMax      = 7;

  typedef struct packed {
    logic [DmiAddrMax-1:0] addr;
    logic [1:0]            op;
    logic [31:0]           data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_jtag_dtm.sv
// DTM core in the TCK domain: DTMCS/DMI scan registers and the DMI request/response
// handshake toward the clock-domain crossing.
module dmi_jtag_dtm
  import dm_pkg::*;
#(
  parameter int unsigned AbitsWidth = 7,
  parameter logic [2:0]  IdleCycles = 3'd1,
  parameter logic [3:0]  Version    = 4'd1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  capture_i,
  input  logic                  shift_i,
  input  logic                  update_i,
  input  logic                  tdi_i,
  input  logic                  dtmcs_select_i,
  output logic                  dtmcs_tdo_o,
  input  logic                  dmi_select_i,
  output logic                  dmi_tdo_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output logic [AbitsWidth-1:0] dmi_req_addr_o,
  output logic [1:0]            dmi_req_op_o,
  output logic [31:0]           dmi_req_data_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  logic [31:0]           dmi_resp_data_i,
  input  logic [1:0]            dmi_resp_resp_i,
  output logic                  dmi_clear_o
);

  localparam int unsigned DmiWidth = AbitsWidth + 34;

  dtm_fsm_e              r_state, w_state_n;
  logic [1:0]            r_error, w_error_n;
  logic [AbitsWidth-1:0] r_addr, w_addr_n;
  logic [31:0]           r_data, w_data_n;
  logic [1:0]            r_op, w_op_n;
  logic [31:0]           r_dtmcs_sr, w_dtmcs_sr_n;
  logic [DmiWidth-1:0]   r_dmi_sr, w_dmi_sr_n;
  logic                  r_clear, w_clear_n;
  logic                  w_req_valid, w_resp_ready;
  logic                  w_dtmcs_act, w_dmi_act;
  logic [1:0]            w_dmi_upd_op;
  dtmcs_t                w_dtmcs_rd;

  // DTMCS owns the strobes whenever both chains claim to be selected.
  assign w_dtmcs_act  = dtmcs_select_i;
  assign w_dmi_act    = dmi_select_i & ~dtmcs_select_i;
  assign w_dmi_upd_op = r_dmi_sr[1:0];

  always_comb begin
    w_dtmcs_rd         = '0;
    w_dtmcs_rd.idle    = IdleCycles;
    w_dtmcs_rd.dmistat = r_error;
    w_dtmcs_rd.abits   = 6'(AbitsWidth);
    w_dtmcs_rd.version = Version;
  end

  always_comb begin
    w_state_n    = r_state;
    w_error_n    = r_error;
    w_addr_n     = r_addr;
    w_data_n     = r_data;
    w_op_n       = r_op;
    w_dtmcs_sr_n = r_dtmcs_sr;
    w_dmi_sr_n   = r_dmi_sr;
    w_clear_n    = 1'b0;
    w_req_valid  = 1'b0;
    w_resp_ready = 1'b0;

    unique case (r_state)
      Request: begin
        w_req_valid = 1'b1;
        if (dmi_req_ready_i) w_state_n = WaitResp;
      end
      WaitResp: begin
        w_resp_ready = 1'b1;
        if (dmi_resp_valid_i) begin
          w_data_n = dmi_resp_data_i;
          if (dmi_resp_resp_i != DmiSuccess) w_error_n = dmi_resp_resp_i;
          w_state_n = Idle;
        end
      end
      default: ;
    endcase

    if (w_dmi_act) begin
      if (capture_i) begin
        w_dmi_sr_n = {r_addr, r_data, r_error};
        if (r_state != Idle) begin
          w_dmi_sr_n[1:0] = DmiBusy;
          w_error_n       = DmiBusy;
        end
      end else if (shift_i) begin
        w_dmi_sr_n = {tdi_i, r_dmi_sr[DmiWidth-1:1]};
      end else if (update_i && r_error == DmiSuccess) begin
        if (r_state != Idle) begin
          w_error_n = DmiBusy;
        end else if (w_dmi_upd_op == Read || w_dmi_upd_op == Write) begin
          w_addr_n  = r_dmi_sr[DmiWidth-1:34];
          w_data_n  = r_dmi_sr[33:2];
          w_op_n    = w_dmi_upd_op;
          w_state_n = Request;
        end
      end
    end

    // Hard reset overrides any same-cycle handshake so a late response is dropped.
    if (w_dtmcs_act) begin
      if (capture_i) begin
        w_dtmcs_sr_n = w_dtmcs_rd;
      end else if (shift_i) begin
        w_dtmcs_sr_n = {tdi_i, r_dtmcs_sr[31:1]};
      end else if (update_i) begin
        if (r_dtmcs_sr[DmiResetBit]) w_error_n = '0;
        if (r_dtmcs_sr[DmiHardResetBit]) begin
          w_error_n = '0;
          w_data_n  = r_data;
          w_state_n = Idle;
          w_clear_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= Idle;
      r_error    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_op       <= '0;
      r_dtmcs_sr <= '0;
      r_dmi_sr   <= '0;
      r_clear    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_error    <= w_error_n;
      r_addr     <= w_addr_n;
      r_data     <= w_data_n;
      r_op       <= w_op_n;
      r_dtmcs_sr <= w_dtmcs_sr_n;
      r_dmi_sr   <= w_dmi_sr_n;
      r_clear    <= w_clear_n;
    end
  end

  assign dtmcs_tdo_o      = r_dtmcs_sr[0];
  assign dmi_tdo_o        = r_dmi_sr[0];
  assign dmi_req_valid_o  = w_req_valid;
  assign dmi_resp_ready_o = w_resp_ready;
  assign dmi_req_addr_o   = r_addr;
  assign dmi_req_op_o     = r_op;
  assign dmi_req_data_o   = r_data;
  assign dmi_clear_o      = r_clear;

endmodule
